// File: rtl/vend_sequencer_if.sv
// Vending sequencer request/status bundle.
// The master side issues vend requests and hopper acks.
// The slave side is the sequencer, which reports status and drives the motor and hopper.
interface vend_sequencer_if;
  logic       start;
  logic [3:0] product;
  logic [2:0] credit;
  logic       coin_ack;
  logic       busy;
  logic       motor_en;
  logic [3:0] vend_led;
  logic       coin_req;
  logic [2:0] change_left;
  logic       done;
  logic       reject;
  logic       fault;

  modport master (
    output start, product, credit, coin_ack,
    input  busy, motor_en, vend_led, coin_req, change_left, done, reject, fault
  );

  modport slave (
    input  start, product, credit, coin_ack,
    output busy, motor_en, vend_led, coin_req, change_left, done, reject, fault
  );
endinterface

// File: rtl/vend_sequencer.sv
// Vending sequencer: price check, timed motor run, nickel-by-nickel change
// payout with a hopper acknowledge timeout. All outputs come straight from flops.
module vend_sequencer #(
  parameter int unsigned MOTOR_CYCLES = 8,
  parameter int unsigned ACK_TIMEOUT  = 200
) (
  input logic              clk,
  input logic              clr,
  vend_sequencer_if.slave  vif
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_MOTOR   = 3'd2,
    ST_CHG_REQ = 3'd3,
    ST_CHG_GAP = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAULT   = 3'd6
  } state_t;

  localparam logic [7:0] MOTOR_LAST = 8'(MOTOR_CYCLES);
  localparam logic [7:0] ACK_LAST   = 8'(ACK_TIMEOUT - 1);

  // Price lookup: {valid one-hot select, price in nickels}.
  function automatic logic [3:0] price_of(input logic [3:0] sel);
    case (sel)
      4'b0001: price_of = {1'b1, 3'd3};
      4'b0010: price_of = {1'b1, 3'd4};
      4'b0100: price_of = {1'b1, 3'd5};
      4'b1000: price_of = {1'b1, 3'd6};
      default: price_of = {1'b0, 3'd0};
    endcase
  endfunction

  state_t     state_r;
  logic [3:0] prod_r;
  logic [2:0] chg_pend_r;
  logic       accept_r;
  logic [7:0] mcnt_r;
  logic [7:0] tcnt_r;
  logic       busy_r;
  logic       motor_en_r;
  logic [3:0] vend_led_r;
  logic       coin_req_r;
  logic [2:0] change_left_r;
  logic       done_r;
  logic       reject_r;
  logic       fault_r;

  logic [3:0] price_info_s;
  logic       accept_s;
  logic [2:0] change_s;

  // Evaluate the live request so the verdict is registered on the accept edge
  // and reject can be shown during the CHECK cycle itself.
  always_comb begin
    price_info_s = price_of(vif.product);
    accept_s     = price_info_s[3] && (vif.credit >= price_info_s[2:0]);
    change_s     = vif.credit - price_info_s[2:0];
  end

  // Sequencer state machine with all outputs registered.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r       <= ST_IDLE;
      prod_r        <= 4'd0;
      chg_pend_r    <= 3'd0;
      accept_r      <= 1'b0;
      mcnt_r        <= 8'd0;
      tcnt_r        <= 8'd0;
      busy_r        <= 1'b0;
      motor_en_r    <= 1'b0;
      vend_led_r    <= 4'd0;
      coin_req_r    <= 1'b0;
      change_left_r <= 3'd0;
      done_r        <= 1'b0;
      reject_r      <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      reject_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (vif.start) begin
            prod_r     <= vif.product;
            chg_pend_r <= change_s;
            accept_r   <= accept_s;
            reject_r   <= !accept_s;
            busy_r     <= 1'b1;
            state_r    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (accept_r) begin
            change_left_r <= chg_pend_r;
            vend_led_r    <= prod_r;
            motor_en_r    <= 1'b1;
            mcnt_r        <= 8'd1;
            state_r       <= ST_MOTOR;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_MOTOR: begin
          if (mcnt_r == MOTOR_LAST) begin
            motor_en_r <= 1'b0;
            mcnt_r     <= 8'd0;
            if (change_left_r == 3'd0) begin
              done_r     <= 1'b1;
              vend_led_r <= 4'd0;
              state_r    <= ST_DONE;
            end else begin
              coin_req_r <= 1'b1;
              tcnt_r     <= 8'd0;
              state_r    <= ST_CHG_REQ;
            end
          end else begin
            mcnt_r <= mcnt_r + 8'd1;
          end
        end
        ST_CHG_REQ: begin
          // An ack on the expiry cycle still counts as a payout.
          if (vif.coin_ack) begin
            coin_req_r    <= 1'b0;
            change_left_r <= change_left_r - 3'd1;
            state_r       <= ST_CHG_GAP;
          end else if (tcnt_r == ACK_LAST) begin
            coin_req_r <= 1'b0;
            fault_r    <= 1'b1;
            state_r    <= ST_FAULT;
          end else begin
            tcnt_r <= tcnt_r + 8'd1;
          end
        end
        ST_CHG_GAP: begin
          if (change_left_r == 3'd0) begin
            done_r     <= 1'b1;
            vend_led_r <= 4'd0;
            state_r    <= ST_DONE;
          end else begin
            coin_req_r <= 1'b1;
            tcnt_r     <= 8'd0;
            state_r    <= ST_CHG_REQ;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        ST_FAULT: begin
          // Sticky until reset; outputs stay frozen.
          fault_r    <= 1'b1;
          coin_req_r <= 1'b0;
          motor_en_r <= 1'b0;
          busy_r     <= 1'b1;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          motor_en_r <= 1'b0;
          coin_req_r <= 1'b0;
          vend_led_r <= 4'd0;
        end
      endcase
    end
  end

  assign vif.busy        = busy_r;
  assign vif.motor_en    = motor_en_r;
  assign vif.vend_led    = vend_led_r;
  assign vif.coin_req    = coin_req_r;
  assign vif.change_left = change_left_r;
  assign vif.done        = done_r;
  assign vif.reject      = reject_r;
  assign vif.fault       = fault_r;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer. Inputs change and outputs are sampled on
// the falling clock edge. The observed output bundle is compared against hand-computed
// vectors: {busy, motor_en, vend_led, coin_req, change_left, done, reject, fault}.
module tb_vend_sequencer;
  logic clk;
  logic clr;
  int   vecs;
  int   fails;
  logic [12:0] obs;
  logic [12:0] exp;

  vend_sequencer_if vif ();

  vend_sequencer #(.MOTOR_CYCLES(8), .ACK_TIMEOUT(200)) dut (
    .clk (clk),
    .clr (clr),
    .vif (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {vif.busy, vif.motor_en, vif.vend_led, vif.coin_req,
                vif.change_left, vif.done, vif.reject, vif.fault};

  function automatic logic [12:0] pk(input logic b, input logic m, input logic [3:0] led,
                                     input logic cr, input logic [2:0] chg,
                                     input logic d, input logic r, input logic f);
    pk = {b, m, led, cr, chg, d, r, f};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    vif.start = 1'b0; vif.product = 4'd0; vif.credit = 3'd0; vif.coin_ack = 1'b0;
    #2;
    exp = pk(1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    vecs++; if (obs !== exp) begin fails++; $display("FAIL reset_state: got %h want %h", obs, exp); end
    tick(); clr = 1'b1;
    tick();
    vecs++; if (obs !== exp) begin fails++; $display("FAIL reset_idle: got %h want %h", obs, exp); end
  endtask

  // 20c product with exact credit, then a start held through DONE is ignored.
  task automatic test_vend();
    vif.start = 1'b1; vif.product = 4'b0010; vif.credit = 3'd4;
    tick();
    vif.start = 1'b0; vif.product = 4'b1111; vif.credit = 3'd0;
    exp = pk(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    vecs++; if (obs !== exp) begin fails++; $display("FAIL vend_check: got %h want %h", obs, exp); end
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = pk(1'b1, 1'b1, 4'b0010, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      vecs++; if (obs !== exp) begin fails++; $display("FAIL vend_motor[%0d]: got %h want %h", i, obs, exp); end
    end
    tick();
    exp = pk(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    vecs++; if (obs !== exp) begin fails++; $display("FAIL vend_done: got %h want %h", obs, exp); end
    vif.start = 1'b1; vif.product = 4'b0010; vif.credit = 3'd4;
    tick();
    vif.start = 1'b0;
    exp = pk(1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    vecs++; if (obs !== exp) begin fails++; $display("FAIL vend_idle: got %h want %h", obs, exp); end
  endtask

  // 15c product with 35c credit: four nickels, ack 3 cycles after each request.
  task automatic test_change();
    vif.start = 1'b1; vif.product = 4'b0001; vif.credit = 3'd7;
    tick();
    vif.start = 1'b0;
    exp = pk(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    vecs++; if (obs !== exp) begin fails++; $display("FAIL chg_check: got %h want %h", obs, exp); end
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = pk(1'b1, 1'b1, 4'b0001, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
      vecs++; if (obs !== exp) begin fails++; $display("FAIL chg_motor[%0d]: got %h want %h", i, obs, exp); end
    end
    for (int c = 4; c >= 1; c--) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        exp = pk(1'b1, 1'b0, 4'b0001, 1'b1, 3'(c), 1'b0, 1'b0, 1'b0);
        vecs++; if (obs !== exp) begin fails++; $display("FAIL chg_req[%0d.%0d]: got %h want %h", c, k, obs, exp); end
      end
      vif.coin_ack = 1'b1;
      tick();
      vif.coin_ack = 1'b0;
      exp = pk(1'b1, 1'b0, 4'b0001, 1'b0, 3'(c - 1), 1'b0, 1'b0, 1'b0);
      vecs++; if (obs !== exp) begin fails++; $display("FAIL chg_gap[%0d]: got %h want %h", c, obs, exp); end
    end
    tick();
    exp = pk(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    vecs++; if (obs !== exp) begin fails++; $display("FAIL chg_done: got %h want %h", obs, exp); end
    tick();
    exp = pk(1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    vecs++; if (obs !== exp) begin fails++; $display("FAIL chg_idle: got %h want %h", obs, exp); end
  endtask

  // Short credit, non-one-hot select and an empty select are all refused.
  task automatic test_reject();
    logic [3:0] prods [3];
    logic [2:0] creds [3];
    prods[0] = 4'b1000; creds[0] = 3'd5;
    prods[1] = 4'b0011; creds[1] = 3'd7;
    prods[2] = 4'b0000; creds[2] = 3'd7;
    for (int i = 0; i < 3; i++) begin
      vif.start = 1'b1; vif.product = prods[i]; vif.credit = creds[i];
      tick();
      vif.start = 1'b0;
      exp = pk(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
      vecs++; if (obs !== exp) begin fails++; $display("FAIL rej_pulse[%0d]: got %h want %h", i, obs, exp); end
      tick();
      exp = pk(1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      vecs++; if (obs !== exp) begin fails++; $display("FAIL rej_idle[%0d]: got %h want %h", i, obs, exp); end
    end
  endtask

  // No ack: coin_req held 200 cycles, then sticky fault; reset clears it.
  task automatic test_fault();
    vif.start = 1'b1; vif.product = 4'b0100; vif.credit = 3'd7;
    tick();
    vif.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = pk(1'b1, 1'b1, 4'b0100, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
      vecs++; if (obs !== exp) begin fails++; $display("FAIL flt_motor[%0d]: got %h want %h", i, obs, exp); end
    end
    for (int k = 0; k < 200; k++) begin
      tick();
      exp = pk(1'b1, 1'b0, 4'b0100, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
      vecs++; if (obs !== exp) begin fails++; $display("FAIL flt_req[%0d]: got %h want %h", k, obs, exp); end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      exp = pk(1'b1, 1'b0, 4'b0100, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1);
      vecs++; if (obs !== exp) begin fails++; $display("FAIL flt_sticky[%0d]: got %h want %h", k, obs, exp); end
      vif.coin_ack = 1'b1; vif.start = 1'b1;
    end
    #2 clr = 1'b0;
    vif.coin_ack = 1'b0; vif.start = 1'b0;
    #1;
    exp = pk(1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    vecs++; if (obs !== exp) begin fails++; $display("FAIL flt_clr: got %h want %h", obs, exp); end
    tick(); clr = 1'b1;
  endtask

  // Reset pulse mid-motor aborts asynchronously; the next start vends normally.
  task automatic test_reset_motor();
    vif.start = 1'b1; vif.product = 4'b0010; vif.credit = 3'd4;
    tick();
    vif.start = 1'b0;
    tick(); tick(); tick();
    #2 clr = 1'b0;
    #1;
    exp = pk(1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    vecs++; if (obs !== exp) begin fails++; $display("FAIL rstm_async: got %h want %h", obs, exp); end
    tick(); clr = 1'b1;
    vif.start = 1'b1; vif.product = 4'b0010; vif.credit = 3'd4;
    tick();
    vif.start = 1'b0;
    exp = pk(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    vecs++; if (obs !== exp) begin fails++; $display("FAIL rstm_check: got %h want %h", obs, exp); end
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = pk(1'b1, 1'b1, 4'b0010, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      vecs++; if (obs !== exp) begin fails++; $display("FAIL rstm_motor[%0d]: got %h want %h", i, obs, exp); end
    end
    tick();
    exp = pk(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    vecs++; if (obs !== exp) begin fails++; $display("FAIL rstm_done: got %h want %h", obs, exp); end
    tick();
  endtask

  // Stray start/ack during MOTOR ignored; ack on the 200th request cycle counts.
  task automatic test_expiry();
    vif.start = 1'b1; vif.product = 4'b0001; vif.credit = 3'd4;
    tick();
    vif.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = pk(1'b1, 1'b1, 4'b0001, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
      vecs++; if (obs !== exp) begin fails++; $display("FAIL exp_motor[%0d]: got %h want %h", i, obs, exp); end
      if (i == 2) begin vif.start = 1'b1; vif.coin_ack = 1'b1; end
      if (i == 4) begin vif.start = 1'b0; vif.coin_ack = 1'b0; end
    end
    for (int k = 0; k < 200; k++) begin
      tick();
      exp = pk(1'b1, 1'b0, 4'b0001, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
      vecs++; if (obs !== exp) begin fails++; $display("FAIL exp_req[%0d]: got %h want %h", k, obs, exp); end
    end
    vif.coin_ack = 1'b1;
    tick();
    vif.coin_ack = 1'b0;
    exp = pk(1'b1, 1'b0, 4'b0001, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    vecs++; if (obs !== exp) begin fails++; $display("FAIL exp_gap: got %h want %h", obs, exp); end
    tick();
    exp = pk(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    vecs++; if (obs !== exp) begin fails++; $display("FAIL exp_done: got %h want %h", obs, exp); end
    tick();
    exp = pk(1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    vecs++; if (obs !== exp) begin fails++; $display("FAIL exp_idle: got %h want %h", obs, exp); end
  endtask

  initial begin
    vecs  = 0;
    fails = 0;
    test_reset();
    test_vend();
    test_change();
    test_reject();
    test_fault();
    test_reset_motor();
    test_expiry();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
